// File: rtl/bpu_pkg.sv
// ---------------------------------------------------------------------------
// bpu_pkg
// Shared types and constants for the branch resolution controller.
//   branch_entry_t : one in-flight predicted branch {pc, target, dir, pred}
//   ctrl_state_t   : flush/redirect sequencer states
//   DIR_FWD/DIR_BWD: values of the branch direction bit (offset sign)
//   CTR_MAX        : saturation ceiling of the 2-bit direction counters
// Entries store addresses at BPU_ADDR_W bits; the controller's DATA_WIDTH
// must not exceed it.
// ---------------------------------------------------------------------------
package bpu_pkg;

    localparam int BPU_ADDR_W = 32;

    localparam logic       DIR_FWD = 1'b0;
    localparam logic       DIR_BWD = 1'b1;
    localparam logic [1:0] CTR_MAX = 2'b11;

    typedef struct packed {
        logic [BPU_ADDR_W-1:0] pc;
        logic [BPU_ADDR_W-1:0] target;
        logic                  dir;
        logic                  pred;
    } branch_entry_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// 2-bit saturating up/down counter used as a branch direction predictor.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, loads INIT
//   en   : train this cycle
//   up   : 1 = count up (saturate at CTR_MAX), 0 = count down (saturate at 0)
//   ctr  : current counter value
// ---------------------------------------------------------------------------
module sat_counter2
    import bpu_pkg::*;
#(
    parameter logic [1:0] INIT = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    output logic [1:0] ctr
);

    logic [1:0] ctr_r;

    // Counter state: saturating train on enable, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_r <= INIT;
        end else if (en) begin
            if (up && (ctr_r != CTR_MAX)) begin
                ctr_r <= ctr_r + 2'b01;
            end else if (!up && (ctr_r != 2'b00)) begin
                ctr_r <= ctr_r - 2'b01;
            end else begin
                ctr_r <= ctr_r;
            end
        end else begin
            ctr_r <= ctr_r;
        end
    end

    assign ctr = ctr_r;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
// Tracks predicted conditional branches from fetch until execute resolves
// them, trains the forward/backward direction counters, and on a
// mispredict issues a one-cycle registered flush + PC redirect.
// Ports:
//   clk, rst          : clock / synchronous active-high reset
//   pushF, pcF, targetF, dirF, predF : fetched predicted branch
//   BranchE, ZeroE    : oldest branch resolves, actual outcome (1 = taken)
//   fwdTaken, bwdTaken: MSB of forward / backward direction counters
//   stallF            : queue full
//   flushBranch, PCRedirect, PCRedirectSrc : redirect sequence outputs
//   resolveErr        : sticky, resolution seen with an empty queue
//   statResolved, statMispredict : resolution statistics (BPU_STATS_EN only)
// Optional feature macro: BPU_STATS_EN
// ---------------------------------------------------------------------------
module branch_resolve_ctrl
    import bpu_pkg::*;
#(
    parameter int         DATA_WIDTH  = 32,
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [1:0] CTR_INIT    = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pushF,
    input  logic [DATA_WIDTH-1:0] pcF,
    input  logic [DATA_WIDTH-1:0] targetF,
    input  logic                  dirF,
    input  logic                  predF,
    input  logic                  BranchE,
    input  logic                  ZeroE,
    output logic                  fwdTaken,
    output logic                  bwdTaken,
    output logic                  stallF,
    output logic                  flushBranch,
    output logic [DATA_WIDTH-1:0] PCRedirect,
    output logic                  PCRedirectSrc,
    output logic                  resolveErr
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]           statResolved,
    output logic [31:0]           statMispredict
`endif
);

    localparam int                    PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0]        FULL_CT = (PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

    branch_entry_t         queue_r [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rdPtr_r;
    logic [PTR_W-1:0]      wrPtr_r;
    logic [PTR_W:0]        count_r;
    ctrl_state_t           state_r;
    logic                  flush_r;
    logic                  redirSrc_r;
    logic [DATA_WIDTH-1:0] redirPc_r;
    logic                  resolveErr_r;

    branch_entry_t         headEntry_s;
    branch_entry_t         newEntry_s;
    logic                  idle_s;
    logic                  full_s;
    logic                  popValid_s;
    logic                  emptyErr_s;
    logic                  mispredict_s;
    logic                  pushOk_s;
    logic                  trainFwd_s;
    logic                  trainBwd_s;
    logic [DATA_WIDTH-1:0] redirTarget_s;
    logic [1:0]            fwdCtr_s;
    logic [1:0]            bwdCtr_s;

    // Resolution decode: pop/train/mispredict and push acceptance.
    always_comb begin
        idle_s        = (state_r == IDLE);
        full_s        = (count_r == FULL_CT);
        headEntry_s   = queue_r[rdPtr_r];
        newEntry_s    = '{pc: BPU_ADDR_W'(pcF), target: BPU_ADDR_W'(targetF),
                          dir: dirF, pred: predF};
        popValid_s    = idle_s && BranchE && (count_r != '0);
        emptyErr_s    = idle_s && BranchE && (count_r == '0);
        mispredict_s  = popValid_s && (headEntry_s.pred != ZeroE);
        // A pop frees the head slot this cycle, so a full queue still takes
        // a push alongside a pop; wrong-path pushes are discarded.
        pushOk_s      = idle_s && pushF && (!full_s || popValid_s) && !mispredict_s;
        trainFwd_s    = popValid_s && (headEntry_s.dir == DIR_FWD);
        trainBwd_s    = popValid_s && (headEntry_s.dir == DIR_BWD);
        if (ZeroE) begin
            redirTarget_s = DATA_WIDTH'(headEntry_s.target);
        end else begin
            redirTarget_s = DATA_WIDTH'(headEntry_s.pc) + PC_STEP;
        end
    end

    // Entry storage: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (pushOk_s) begin
            queue_r[wrPtr_r] <= newEntry_s;
        end
    end

    // Queue pointers and occupancy; a mispredict empties the queue.
    always_ff @(posedge clk) begin
        if (rst || mispredict_s) begin
            rdPtr_r <= '0;
            wrPtr_r <= '0;
            count_r <= '0;
        end else begin
            rdPtr_r <= popValid_s ? rdPtr_r + PTR_W'(1) : rdPtr_r;
            wrPtr_r <= pushOk_s   ? wrPtr_r + PTR_W'(1) : wrPtr_r;
            case ({pushOk_s, popValid_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Redirect sequencer: REDIRECT lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            flush_r      <= 1'b0;
            redirSrc_r   <= 1'b0;
            redirPc_r    <= '0;
            resolveErr_r <= 1'b0;
        end else begin
            state_r      <= mispredict_s ? REDIRECT : IDLE;
            flush_r      <= mispredict_s;
            redirSrc_r   <= mispredict_s;
            redirPc_r    <= mispredict_s ? redirTarget_s : redirPc_r;
            resolveErr_r <= resolveErr_r | emptyErr_s;
        end
    end

    sat_counter2 #(.INIT(CTR_INIT)) uFwdCtr (
        .clk (clk), .rst (rst), .en (trainFwd_s), .up (ZeroE), .ctr (fwdCtr_s)
    );

    sat_counter2 #(.INIT(CTR_INIT)) uBwdCtr (
        .clk (clk), .rst (rst), .en (trainBwd_s), .up (ZeroE), .ctr (bwdCtr_s)
    );

`ifdef BPU_STATS_EN
    logic [31:0] statResolved_r;
    logic [31:0] statMispredict_r;

    // Resolution statistics, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            statResolved_r   <= 32'd0;
            statMispredict_r <= 32'd0;
        end else begin
            statResolved_r   <= popValid_s   ? statResolved_r + 32'd1   : statResolved_r;
            statMispredict_r <= mispredict_s ? statMispredict_r + 32'd1 : statMispredict_r;
        end
    end

    assign statResolved   = statResolved_r;
    assign statMispredict = statMispredict_r;
`endif

    assign fwdTaken      = fwdCtr_s[1];
    assign bwdTaken      = bwdCtr_s[1];
    assign stallF        = full_s;
    assign flushBranch   = flush_r;
    assign PCRedirectSrc = redirSrc_r;
    assign PCRedirect    = redirPc_r;
    assign resolveErr    = resolveErr_r;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed scenario tasks followed by randomized traffic checked against a
// queue-based reference model of the branch resolution controller.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst, pushF, dirF, predF, BranchE, ZeroE;
    logic [31:0] pcF, targetF;
    logic        fwdTaken, bwdTaken, stallF, flushBranch, PCRedirectSrc, resolveErr;
    logic [31:0] PCRedirect;
`ifdef BPU_STATS_EN
    logic [31:0] statResolved, statMispredict;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DATA_WIDTH(32), .QUEUE_DEPTH(4), .CTR_INIT(2'b10)) dut (
        .clk(clk), .rst(rst), .pushF(pushF), .pcF(pcF), .targetF(targetF),
        .dirF(dirF), .predF(predF), .BranchE(BranchE), .ZeroE(ZeroE),
        .fwdTaken(fwdTaken), .bwdTaken(bwdTaken), .stallF(stallF),
        .flushBranch(flushBranch), .PCRedirect(PCRedirect),
        .PCRedirectSrc(PCRedirectSrc), .resolveErr(resolveErr)
`ifdef BPU_STATS_EN
        , .statResolved(statResolved), .statMispredict(statMispredict)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        bit          dir;
        bit          pred;
    } ent_t;

    ent_t        mq[$];
    int          mFwd, mBwd;
    bit          mRedir, mErr;
    logic [31:0] mRedirPc;
    int unsigned mResolved, mMispred;

    task automatic modelStep();
        ent_t h;
        bit   mis;
        if (rst) begin
            mq.delete();
            mFwd = 2; mBwd = 2;
            mRedir = 0; mErr = 0; mRedirPc = 32'd0;
            mResolved = 0; mMispred = 0;
        end else if (mRedir) begin
            mRedir = 0;
        end else begin
            mis = 0;
            if (BranchE) begin
                if (mq.size() == 0) begin
                    mErr = 1;
                end else begin
                    h = mq.pop_front();
                    mResolved++;
                    if (h.dir) mBwd = ZeroE ? ((mBwd < 3) ? mBwd + 1 : 3) : ((mBwd > 0) ? mBwd - 1 : 0);
                    else       mFwd = ZeroE ? ((mFwd < 3) ? mFwd + 1 : 3) : ((mFwd > 0) ? mFwd - 1 : 0);
                    if (h.pred != ZeroE) begin
                        mis = 1;
                        mMispred++;
                        mRedirPc = ZeroE ? h.target : h.pc + 32'd4;
                        mq.delete();
                    end
                end
            end
            if (pushF && !mis && mq.size() < 4)
                mq.push_back('{pc: pcF, target: targetF, dir: dirF, pred: predF});
            mRedir = mis;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample at negedge.
    task automatic cycle(input bit r, input bit p, input logic [31:0] pc, input logic [31:0] tg,
                         input bit d, input bit pr, input bit be, input bit z);
        rst = r; pushF = p; pcF = pc; targetF = tg; dirF = d; predF = pr; BranchE = be; ZeroE = z;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        cycle(1, 1, 32'h0000_0AA0, 32'h0000_0BB0, 0, 1, 1, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cycle(1, 1, 32'h0000_0AA0, 32'h0000_0BB0, 1, 1, 1, 1);
        if (flushBranch !== 1'b0)      begin miscompares++; $display("FAIL reset_flush got=%0b exp=0", flushBranch); end vectors++;
        if (PCRedirectSrc !== 1'b0)    begin miscompares++; $display("FAIL reset_src got=%0b exp=0", PCRedirectSrc); end vectors++;
        if (stallF !== 1'b0)           begin miscompares++; $display("FAIL reset_stall got=%0b exp=0", stallF); end vectors++;
        if (resolveErr !== 1'b0)       begin miscompares++; $display("FAIL reset_err got=%0b exp=0", resolveErr); end vectors++;
        if (PCRedirect !== 32'd0)      begin miscompares++; $display("FAIL reset_pc got=%h exp=0", PCRedirect); end vectors++;
        if ({fwdTaken, bwdTaken} !== 2'b11) begin miscompares++; $display("FAIL reset_ctrs got=%b exp=11", {fwdTaken, bwdTaken}); end vectors++;
    endtask

    task automatic test_correct_pred();
        doReset();
        cycle(0, 1, 32'h100, 32'h140, 0, 1, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        if ({flushBranch, PCRedirectSrc} !== 2'b00) begin miscompares++; $display("FAIL correct_noflush got=%b exp=00", {flushBranch, PCRedirectSrc}); end vectors++;
        if (fwdTaken !== 1'b1) begin miscompares++; $display("FAIL correct_fwd got=%0b exp=1", fwdTaken); end vectors++;
        // Counter is now 3: one not-taken mispredict only brings it to 2.
        cycle(0, 1, 32'h100, 32'h140, 0, 1, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 0);
        if (fwdTaken !== 1'b1) begin miscompares++; $display("FAIL correct_ctr3 got=%0b exp=1", fwdTaken); end vectors++;
        if (PCRedirect !== 32'h104) begin miscompares++; $display("FAIL correct_redir got=%h exp=104", PCRedirect); end vectors++;
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic test_mispredict_fwd();
        doReset();
        cycle(0, 1, 32'h100, 32'h140, 0, 1, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 0);
        if ({flushBranch, PCRedirectSrc} !== 2'b11) begin miscompares++; $display("FAIL misf_pulse got=%b exp=11", {flushBranch, PCRedirectSrc}); end vectors++;
        if (PCRedirect !== 32'h104) begin miscompares++; $display("FAIL misf_pc got=%h exp=104", PCRedirect); end vectors++;
        if ({fwdTaken, bwdTaken} !== 2'b01) begin miscompares++; $display("FAIL misf_ctrs got=%b exp=01", {fwdTaken, bwdTaken}); end vectors++;
        // Push during REDIRECT must be ignored.
        cycle(0, 1, 32'h500, 32'h540, 0, 1, 0, 0);
        if ({flushBranch, PCRedirectSrc} !== 2'b00) begin miscompares++; $display("FAIL misf_onecycle got=%b exp=00", {flushBranch, PCRedirectSrc}); end vectors++;
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        if (resolveErr !== 1'b1) begin miscompares++; $display("FAIL misf_emptied got=%0b exp=1", resolveErr); end vectors++;
        if (flushBranch !== 1'b0) begin miscompares++; $display("FAIL misf_noflush got=%0b exp=0", flushBranch); end vectors++;
    endtask

    task automatic test_mispredict_bwd();
        doReset();
        cycle(0, 1, 32'h200, 32'h1F0, 1, 0, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        if (flushBranch !== 1'b1) begin miscompares++; $display("FAIL misb_flush got=%0b exp=1", flushBranch); end vectors++;
        if (PCRedirect !== 32'h1F0) begin miscompares++; $display("FAIL misb_pc got=%h exp=1f0", PCRedirect); end vectors++;
        if ({fwdTaken, bwdTaken} !== 2'b11) begin miscompares++; $display("FAIL misb_ctrs got=%b exp=11", {fwdTaken, bwdTaken}); end vectors++;
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic test_full();
        doReset();
        for (int k = 0; k < 4; k++)
            cycle(0, 1, 32'h1000 + 32'(k) * 32'h10, 32'h2000 + 32'(k) * 32'h10, 0, 1, 0, 0);
        if (stallF !== 1'b1) begin miscompares++; $display("FAIL full_stall got=%0b exp=1", stallF); end vectors++;
        cycle(0, 1, 32'h3000, 32'h3100, 0, 0, 0, 0);
        if (stallF !== 1'b1) begin miscompares++; $display("FAIL full_drop got=%0b exp=1", stallF); end vectors++;
        // Push alongside a correct pop while full.
        cycle(0, 1, 32'h4000, 32'h4100, 0, 0, 1, 1);
        if ({stallF, flushBranch} !== 2'b10) begin miscompares++; $display("FAIL full_pushpop got=%b exp=10", {stallF, flushBranch}); end vectors++;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
            if ({stallF, flushBranch} !== 2'b00) begin miscompares++; $display("FAIL full_order%0d got=%b exp=00", k, {stallF, flushBranch}); end vectors++;
        end
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        if ({flushBranch, PCRedirect} !== {1'b1, 32'h4100}) begin miscompares++; $display("FAIL full_last got=%0b/%h exp=1/4100", flushBranch, PCRedirect); end vectors++;
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        doReset();
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 32'h300, 32'h380, 0, 0, 0, 0);
            cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 0);
            if ({fwdTaken, flushBranch} !== 2'b00) begin miscompares++; $display("FAIL sat_down%0d got=%b exp=00", k, {fwdTaken, flushBranch}); end vectors++;
        end
        cycle(0, 1, 32'h300, 32'h380, 0, 0, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        if ({fwdTaken, flushBranch} !== 2'b01) begin miscompares++; $display("FAIL sat_up1 got=%b exp=01", {fwdTaken, flushBranch}); end vectors++;
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        cycle(0, 1, 32'h300, 32'h380, 0, 1, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 1);
        if (fwdTaken !== 1'b1) begin miscompares++; $display("FAIL sat_up2 got=%0b exp=1", fwdTaken); end vectors++;
    endtask

    task automatic test_empty_err();
        doReset();
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 0);
        if ({resolveErr, flushBranch} !== 2'b10) begin miscompares++; $display("FAIL empty_err got=%b exp=10", {resolveErr, flushBranch}); end vectors++;
        if ({fwdTaken, bwdTaken} !== 2'b11) begin miscompares++; $display("FAIL empty_ctrs got=%b exp=11", {fwdTaken, bwdTaken}); end vectors++;
        for (int k = 0; k < 3; k++) cycle(0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        if (resolveErr !== 1'b1) begin miscompares++; $display("FAIL empty_sticky got=%0b exp=1", resolveErr); end vectors++;
    endtask

    task automatic test_rst_in_redirect();
        doReset();
        cycle(0, 1, 32'h700, 32'h7C0, 0, 1, 0, 0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 1, 0);
        if (flushBranch !== 1'b1) begin miscompares++; $display("FAIL rstredir_pre got=%0b exp=1", flushBranch); end vectors++;
        cycle(1, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        if ({flushBranch, PCRedirectSrc, stallF, resolveErr} !== 4'b0000) begin miscompares++; $display("FAIL rstredir_flags got=%b exp=0000", {flushBranch, PCRedirectSrc, stallF, resolveErr}); end vectors++;
        if (PCRedirect !== 32'd0) begin miscompares++; $display("FAIL rstredir_pc got=%h exp=0", PCRedirect); end vectors++;
    endtask

    task automatic test_random();
        bit          r, p, d, pr, be, z;
        logic [31:0] pc, tg;
        doReset();
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            p  = ($urandom_range(0, 2) != 0);
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            tg = $urandom() & 32'hFFFF_FFFC;
            d  = $urandom_range(0, 1);
            pr = $urandom_range(0, 1);
            be = ($urandom_range(0, 2) == 0);
            z  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].pred : 1'($urandom_range(0, 1));
            cycle(r, p, pc, tg, d, pr, be, z);
            if ({flushBranch, PCRedirectSrc} !== {mRedir, mRedir}) begin miscompares++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, {flushBranch, PCRedirectSrc}, {mRedir, mRedir}); end vectors++;
            if (PCRedirect !== mRedirPc) begin miscompares++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, PCRedirect, mRedirPc); end vectors++;
            if (stallF !== (mq.size() == 4)) begin miscompares++; $display("FAIL rnd_stall i=%0d got=%0b exp=%0b", i, stallF, mq.size() == 4); end vectors++;
            if ({fwdTaken, bwdTaken} !== {mFwd >= 2, mBwd >= 2}) begin miscompares++; $display("FAIL rnd_ctrs i=%0d got=%b exp=%0d/%0d", i, {fwdTaken, bwdTaken}, mFwd, mBwd); end vectors++;
            if (resolveErr !== mErr) begin miscompares++; $display("FAIL rnd_err i=%0d got=%0b exp=%0b", i, resolveErr, mErr); end vectors++;
`ifdef BPU_STATS_EN
            if ({statResolved, statMispredict} !== {32'(mResolved), 32'(mMispred)}) begin miscompares++; $display("FAIL rnd_stats i=%0d got=%0d/%0d exp=%0d/%0d", i, statResolved, statMispredict, mResolved, mMispred); end vectors++;
`endif
        end
    endtask

    initial begin
        rst = 1'b1; pushF = 1'b0; pcF = 32'd0; targetF = 32'd0;
        dirF = 1'b0; predF = 1'b0; BranchE = 1'b0; ZeroE = 1'b0;
        test_reset();
        test_correct_pred();
        test_mispredict_fwd();
        test_mispredict_bwd();
        test_full();
        test_saturate();
        test_empty_err();
        test_rst_in_redirect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Tracks the sequencing of in-flight conditional branches between fetch-time prediction and execute-time resolution.
- Holds a fixed-depth FIFO of predicted branches and owns the forward and backward 2-bit direction counters.
- Compares each resolution against the oldest prediction and, on mismatch, runs a registered flush/redirect sequence.
- Sits beside the fetch-stage predictor: the predictor reads this block's counters, and this block drives the PC mux and the pipeline flush.

Parameters:
- DATA_WIDTH, 32, PC/address width.
- QUEUE_DEPTH, 4, number of in-flight branch entries (power of 2, at least 2).
- CTR_INIT, 2'b10, reset value of both direction counters (weakly taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- pushF  in  1  predicted conditional branch fetched this cycle.
- pcF  in  DATA_WIDTH  PC of the fetched branch.
- targetF  in  DATA_WIDTH  computed branch target.
- dirF  in  1  0 = forward, 1 = backward (sign bit of the offset).
- predF  in  1  prediction used by fetch (1 = taken).
- BranchE  in  1  oldest in-flight branch resolves this cycle.
- ZeroE  in  1  actual outcome (1 = taken).
- fwdTaken  out  1  fwdCtr[1]; forward-branch prediction.
- bwdTaken  out  1  bwdCtr[1]; backward-branch prediction.
- stallF  out  1  queue full; fetch must hold.
- flushBranch  out  1  flush the F/D/E younger stages.
- PCRedirect  out  DATA_WIDTH  corrected PC.
- PCRedirectSrc  out  1  select PCRedirect at the PC mux.
- resolveErr  out  1  sticky: BranchE seen while the queue was empty.

Behaviour:
Reset values (rst=1, synchronous):
- Queue empty; rd/wr pointers and count = 0.
- fwdCtr = bwdCtr = CTR_INIT.
- FSM in IDLE.
- flushBranch, PCRedirectSrc, stallF and resolveErr = 0; PCRedirect = 0.
- rst overrides every other input, including mid-flush.

Queue:
- Circular buffer of {pc, target, dir, pred}; count is 0..QUEUE_DEPTH; pointers wrap modulo QUEUE_DEPTH.
- stallF = (count == QUEUE_DEPTH), combinational.
- Push accepted when pushF && !stallF && state == IDLE. Otherwise pushF is dropped silently.
- Pop on BranchE with count > 0. A simultaneous push and pop leaves count unchanged and is legal even when full; the pop frees the slot in the same cycle.

Resolution (count > 0, BranchE=1):
- Head entry h; mispredict = (h.pred != ZeroE).
- Counter selected by h.dir is trained on the actual outcome: ZeroE=1 increments, saturating at 3; ZeroE=0 decrements, saturating at 0.
- If mispredict:
  - Latch PCRedirect = ZeroE ? h.target : h.pc + 4, with mod 2^DATA_WIDTH wrap.
  - Next state is REDIRECT.
  - The whole queue is cleared (count = 0), since younger entries are wrong-path. A push in the same cycle is discarded.
- BranchE with count == 0: no pop, no training, resolveErr set to 1 and held until rst.

FSM:
- IDLE: outputs 0. Moves to REDIRECT on a mispredict.
- REDIRECT: flushBranch = 1 and PCRedirectSrc = 1 for exactly one cycle; pushes and BranchE are ignored. Always returns to IDLE.
- Latency: mispredict at cycle N gives redirect and flush at cycle N+1. A correct prediction produces no output pulse.
- Counter outputs reflect the post-training value from the cycle after the update.

Optional Feature:
BPU_STATS_EN
- Defined: adds outputs statResolved[31:0] and statMispredict[31:0].
  - statResolved increments on each valid pop.
  - statMispredict increments on each mispredict.
  - Both wrap at 2^32 and clear on rst.
- Undefined: both ports and their counters are absent.

Decomposition:
- Package bpu_pkg:
  - branch_entry_t packed struct {pc, target, dir, pred}.
  - ctrl_state_t enum {IDLE, REDIRECT}.
  - Constants DIR_FWD = 0, DIR_BWD = 1, CTR_MAX = 2'b11.
- One sub-module, sat_counter2 (2-bit saturating up/down with enable and init parameter), instantiated twice.

Test Plan:
- Reset, push one forward branch (pc 0x100, target 0x140, pred 1), BranchE with ZeroE=1 -> no flush; fwdCtr goes 2 to 3; count returns to 0.
- Same entry with ZeroE=0 -> next cycle flushBranch=1, PCRedirectSrc=1, PCRedirect=0x104 for one cycle; fwdCtr goes 2 to 1; queue empty.
- Backward branch (pc 0x200, target 0x1F0, pred 0), ZeroE=1 -> redirect to 0x1F0; bwdCtr goes 2 to 3; bwdTaken stays 1.
- Push 4 entries -> stallF=1 and a 5th push is dropped. Push and BranchE together while full -> count stays 4, stallF stays 1, FIFO order preserved over 4 pops.
- Three consecutive not-taken resolutions on forward branches -> fwdCtr goes 2, 1, 0, 0 (saturates); fwdTaken goes 0 after the first.
- BranchE on an empty queue -> resolveErr=1 sticky, no flush, counters unchanged. rst asserted during REDIRECT -> next cycle all outputs 0.
